// File: rtl/spi_mem_cache_pkg.sv
// Shared widths, FSM state type and index-width helper for the SPI memory cache.
package neander_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } cache_state_t;

  // ceil(log2(lines)) for the supported range of 2..64 lines
  function automatic int idx_w(input int lines);
    int w;
    w = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < lines) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_mem_cache_if.sv
// Byte memory request bus, used both between CPU and cache and between cache and SPI controller.
interface spi_mem_cache_if;
  import neander_mem_pkg::*;

  // Handshake: master raises req with we/addr/wdata and keeps them stable until the
  // slave answers with a one-cycle ready pulse; rdata is valid only in that cycle.
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/spi_mem_cache_array.sv
// Valid/tag/data storage: combinational lookup port, synchronous write port, bulk valid clear.
module spi_mem_cache_array
  import neander_mem_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_rd_idx  = i_rd_addr[IDX_W-1:0];
  assign w_wr_idx  = i_wr_addr[IDX_W-1:0];
  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_addr[ADDR_W-1:IDX_W]);
  assign o_rd_data = r_data[w_rd_idx];

  // A flush in the same cycle as a write leaves the line invalid
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= i_wr_addr[ADDR_W-1:IDX_W];
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

endmodule

// File: rtl/spi_mem_cache.sv
// Direct-mapped write-through, no-write-allocate byte cache in front of the SPI memory controller.
// Define SPI_MEM_CACHE_STATS_EN to add saturating read hit/miss counters.
module spi_mem_cache
  import neander_mem_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  spi_mem_cache_if.slave         cpu,
  spi_mem_cache_if.master        mem,
  output cache_state_t           o_dbg_state
`ifdef SPI_MEM_CACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  cache_state_t      r_state;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_fill_flushed;

  logic              w_hit;
  logic              w_rd_hit;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rd_data;

  // A flush in the lookup cycle turns a would-be hit into a miss
  assign w_rd_hit = w_hit && !flush;
  assign w_wr_en  = mem.ready && (((r_state == FILL) && !r_fill_flushed) ||
                                  ((r_state == WRITE) && w_hit));

  spi_mem_cache_array #(.LINES(LINES)) u_array (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .i_rd_addr (cpu.addr),
    .o_hit     (w_hit),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (cpu.addr),
    .i_wr_data ((r_state == FILL) ? mem.rdata : cpu.wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cpu_ready    <= 1'b0;
      r_cpu_rdata    <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_fill_flushed <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu.req) begin
            r_mem_addr  <= cpu.addr;
            r_mem_wdata <= cpu.wdata;
            if (cpu.we) begin
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
              r_state   <= WRITE;
            end else if (w_rd_hit) begin
              r_cpu_rdata <= w_rd_data;
              r_cpu_ready <= 1'b1;
              r_state     <= RESP;
            end else begin
              r_mem_req      <= 1'b1;
              r_mem_we       <= 1'b0;
              r_fill_flushed <= 1'b0;
              r_state        <= FILL;
            end
          end
        end
        FILL: begin
          // Remember any flush seen while the fill is outstanding
          if (flush) r_fill_flushed <= 1'b1;
          if (mem.ready) begin
            r_mem_req   <= 1'b0;
            r_cpu_rdata <= mem.rdata;
            r_cpu_ready <= 1'b1;
            r_state     <= RESP;
          end
        end
        WRITE: begin
          if (mem.ready) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu.ready   = r_cpu_ready;
  assign cpu.rdata   = r_cpu_rdata;
  assign mem.req     = r_mem_req;
  assign mem.we      = r_mem_we;
  assign mem.addr    = r_mem_addr;
  assign mem.wdata   = r_mem_wdata;
  assign o_dbg_state = r_state;

`ifdef SPI_MEM_CACHE_STATS_EN
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if ((r_state == IDLE) && cpu.req && !cpu.we) begin
      if (w_rd_hit) begin
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end else begin
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_spi_mem_cache.sv
// Scoreboard bench for spi_mem_cache: directed CPU traffic, SPI controller model, expected queues.
module tb_spi_mem_cache;
  import neander_mem_pkg::*;

  logic         clk;
  logic         reset;
  logic         flush;
  cache_state_t dbg_state;
`ifdef SPI_MEM_CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  spi_mem_cache_if cpu ();
  spi_mem_cache_if mem ();

  spi_mem_cache #(.LINES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .cpu         (cpu),
    .mem         (mem),
    .o_dbg_state (dbg_state)
`ifdef SPI_MEM_CACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  // {check_flag, data} expected on each cpu_ready pulse
  logic [8:0]  cpu_exp_q[$];
  // {we, addr, wdata} expected on each new mem_req
  logic [24:0] mem_exp_q[$];
  logic [7:0]  mem_data_q[$];
  int          mem_dly = 2;
  bit          flush_on_ready = 1'b0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- SPI controller model + mem-side monitor ----------------
  initial begin : mem_model
    logic [24:0] e;
    bit          aborted;
    mem.ready = 1'b0;
    mem.rdata = 8'h00;
    flush     = 1'b0;
    forever begin
      @(negedge clk);
      if (mem.req === 1'b1) begin
        if (mem_exp_q.size() == 0) begin
          check("mem_unexpected_req", {mem.we, mem.addr}, 32'h0);
          checks--;
          if ({mem.we, mem.addr} == 17'h0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected_req: got req=1 expected no request");
          end
          e = 25'h0;
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_we", mem.we, e[24]);
          check("mem_addr", mem.addr, e[23:8]);
          if (e[24]) check("mem_wdata", mem.wdata, e[7:0]);
        end
        aborted = 1'b0;
        for (int i = 0; i < mem_dly; i++) begin
          @(posedge clk);
          #1;
          if (mem.req !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          mem.ready = 1'b1;
          mem.rdata = (!mem.we && mem_data_q.size() != 0) ? mem_data_q.pop_front() : 8'h00;
          flush     = flush_on_ready;
          @(posedge clk);
          #1;
          mem.ready = 1'b0;
          flush     = 1'b0;
        end
      end
    end
  end

  // ---------------- CPU-side monitor ----------------
  initial begin : cpu_monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (cpu.ready === 1'b1) begin
        if (cpu_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected_ready: got ready=1 rdata=%0h expected no response", cpu.rdata);
        end else begin
          e = cpu_exp_q.pop_front();
          if (e[8]) check("cpu_rdata", cpu.rdata, e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                          output int lat);
    bit done;
    @(posedge clk);
    #1;
    cpu.req   = 1'b1;
    cpu.we    = we;
    cpu.addr  = addr;
    cpu.wdata = wdata;
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (cpu.ready === 1'b1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cpu_ready_timeout: got no ready after %0d cycles expected ready", lat);
    end
    @(posedge clk);
    #1;
    cpu.req = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input bit miss, input int dly);
    int lat;
    cpu_exp_q.push_back({1'b1, exp});
    if (miss) begin
      mem_exp_q.push_back({1'b0, a, 8'h00});
      mem_data_q.push_back(exp);
    end
    mem_dly = dly;
    cpu_xfer(1'b0, a, 8'h00, lat);
    if (!miss) check("hit_latency", lat, 2);
    check("mem_q_drained", mem_exp_q.size(), 0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input int dly);
    int lat;
    cpu_exp_q.push_back({1'b0, 8'h00});
    mem_exp_q.push_back({1'b1, a, d});
    mem_dly = dly;
    cpu_xfer(1'b1, a, d, lat);
    check("mem_q_drained", mem_exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    bit seen;
    reset     = 1'b1;
    cpu.req   = 1'b0;
    cpu.we    = 1'b0;
    cpu.addr  = 16'h0000;
    cpu.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_ready", cpu.ready, 1'b0);
    check("rst_cpu_rdata", cpu.rdata, 8'h00);
    check("rst_mem_req", mem.req, 1'b0);
    check("rst_mem_we", mem.we, 1'b0);
    check("rst_mem_addr", mem.addr, 16'h0000);
    check("rst_state", dbg_state, IDLE);

    rd(16'h0123, 8'h5A, 1'b1, 20);
    rd(16'h0123, 8'h5A, 1'b0, 2);
`ifdef SPI_MEM_CACHE_STATS_EN
    @(negedge clk);
    check("hit_count", hit_count, 16'd1);
    check("miss_count", miss_count, 16'd1);
`endif

    wr(16'h0123, 8'hC3, 3);
    rd(16'h0123, 8'hC3, 1'b0, 2);

    wr(16'h0200, 8'h11, 2);
    rd(16'h0200, 8'h11, 1'b1, 2);

    rd(16'h0010, 8'hAA, 1'b1, 4);
    rd(16'h0020, 8'hBB, 1'b1, 4);
    rd(16'h0010, 8'hAA, 1'b1, 4);

    flush_on_ready = 1'b1;
    rd(16'h0040, 8'h77, 1'b1, 5);
    flush_on_ready = 1'b0;
    rd(16'h0040, 8'h78, 1'b1, 3);

    rd(16'h0300, 8'h42, 1'b1, 2);
    rd(16'h0300, 8'h42, 1'b0, 2);

    // reset while a write is outstanding at the controller
    mem_exp_q.push_back({1'b1, 16'h0300, 8'h99});
    mem_dly = 10;
    @(posedge clk);
    #1;
    cpu.req   = 1'b1;
    cpu.we    = 1'b1;
    cpu.addr  = 16'h0300;
    cpu.wdata = 8'h99;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem.req === 1'b1) seen = 1'b1;
    end
    check("wr_mem_req_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cpu.req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", mem.req, 1'b0);
    check("mid_rst_cpu_ready", cpu.ready, 1'b0);
    check("mid_rst_state", dbg_state, IDLE);
    repeat (15) @(negedge clk);
    check("mem_q_drained", mem_exp_q.size(), 0);
    rd(16'h0300, 8'h42, 1'b1, 2);
    rd(16'h0123, 8'hC3, 1'b1, 2);

    repeat (5) @(negedge clk);
    check("cpu_q_drained", cpu_exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
